// File: rtl/irq_pending_latch_if.sv
// Request/ack/mask bus between the interrupt controller and the pending latch.
// The master drives the strobes and raw lines. The slave returns the masked pending state.
interface irq_pending_latch_if #(
    parameter int N  = 8,
    parameter int IW = 3
);
    logic [N-1:0]  req_in;
    logic          mask_wr;
    logic [N-1:0]  mask_in;
    logic          ack;
    logic [IW-1:0] ack_idx;
    logic          ovf_clr;
    logic [N-1:0]  pend_out;
    logic          irq;
    logic [N-1:0]  overflow;
    logic [N-1:0]  mask_q;

    modport master (
        output req_in, mask_wr, mask_in, ack, ack_idx, ovf_clr,
        input  pend_out, irq, overflow, mask_q
    );

    modport slave (
        input  req_in, mask_wr, mask_in, ack, ack_idx, ovf_clr,
        output pend_out, irq, overflow, mask_q
    );
endinterface

// File: rtl/irq_pending_latch.sv
// Request capture ahead of the 8-to-3 priority encoder. Raw lines are synchronised and
// converted to sticky pending bits, which are masked onto the encoder A input.
module irq_pending_line #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_clr,
    input  logic i_mask_wr,
    input  logic i_mask_bit,
    input  logic i_ovf_clr,
    output logic o_pend,
    output logic o_ovf,
    output logic o_mask
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_pend;
    logic                   r_ovf;
    logic                   r_mask;
    logic                   w_edge;

    // The chain resets to 0, so a line already high at release counts as a rising edge.
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
            r_mask <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
            r_hist <= r_sync[SYNC_STAGES-1];
            // A new edge beats a same-cycle ack: the bit then stands for the new event.
            if (w_edge)
                r_pend <= 1'b1;
            else if (i_clr)
                r_pend <= 1'b0;
            if (w_edge && r_pend && !i_clr)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;
            if (i_mask_wr)
                r_mask <= i_mask_bit;
        end
    end

    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;
    assign o_mask = r_mask;
endmodule

module irq_pending_latch #(
    parameter int N           = 8,
    parameter int IW          = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    irq_pending_latch_if.slave  bus
);
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pend;
    logic [N-1:0] w_ovf;
    logic [N-1:0] w_mask;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_line
            // An index at or above N matches no line, so an out-of-range ack is a no-op.
            assign w_clr[gi] = bus.ack && (bus.ack_idx == IW'(gi));

            irq_pending_line #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_line (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_req      (bus.req_in[gi]),
                .i_clr      (w_clr[gi]),
                .i_mask_wr  (bus.mask_wr),
                .i_mask_bit (bus.mask_in[gi]),
                .i_ovf_clr  (bus.ovf_clr),
                .o_pend     (w_pend[gi]),
                .o_ovf      (w_ovf[gi]),
                .o_mask     (w_mask[gi])
            );
        end
    endgenerate

    assign bus.pend_out = w_pend & ~w_mask;
    assign bus.irq      = |(w_pend & ~w_mask);
    assign bus.overflow = w_ovf;
    assign bus.mask_q   = w_mask;
endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed cases plus random traffic, scored against a
// vector-level reference model through an expected-response queue.
module tb_irq_pending_latch;
    localparam int N = 8;
    localparam int IW = 3;
    localparam int S = 2;

    typedef struct packed {
        logic [N-1:0] pend;
        logic         irq;
        logic [N-1:0] ovf;
        logic [N-1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    irq_pending_latch_if #(.N(N), .IW(IW)) bus ();

    irq_pending_latch #(.N(N), .IW(IW), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: requests sampled at each edge, delayed S edges, edge = rose.
    exp_t         q[$];
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_ovf = '0;
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] m_hist[0:S];
    logic [N-1:0] m_ev;
    logic [N-1:0] m_clr;

    task automatic model_flush();
        m_pend = '0;
        m_ovf  = '0;
        m_mask = '0;
        for (int j = 0; j <= S; j++) m_hist[j] = '0;
    endtask

    task automatic model_step();
        exp_t e;
        if (!rst_n) begin
            model_flush();
        end else begin
            m_ev  = m_hist[S-1] & ~m_hist[S];
            m_clr = bus.ack ? (N'(1) << bus.ack_idx) : '0;
            m_ovf = (m_ev & m_pend & ~m_clr) | (bus.ovf_clr ? '0 : m_ovf);
            m_pend = m_ev | (m_pend & ~m_clr);
            if (bus.mask_wr) m_mask = bus.mask_in;
            for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = bus.req_in;
        end
        e.pend = m_pend & ~m_mask;
        e.irq  = |(m_pend & ~m_mask);
        e.ovf  = m_ovf;
        e.mask = m_mask;
        q.push_back(e);
    endtask

    initial model_flush();
    always @(posedge clk) model_step();
    always @(negedge rst_n) begin
        model_flush();
        q.delete();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle presents a response, compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_pend_out", 32'(bus.pend_out), 32'(e.pend));
            chk("sb_irq",      32'(bus.irq),      32'(e.irq));
            chk("sb_overflow", 32'(bus.overflow), 32'(e.ovf));
            chk("sb_mask_q",   32'(bus.mask_q),   32'(e.mask));
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pend"}, 32'(bus.pend_out), 32'h0);
        chk({nm, "_irq"},  32'(bus.irq),      32'h0);
        chk({nm, "_ovf"},  32'(bus.overflow), 32'h0);
        chk({nm, "_mask"}, 32'(bus.mask_q),   32'h0);
    endtask

    task automatic do_ack(input int idx);
        bus.ack = 1'b1;
        bus.ack_idx = IW'(idx);
        nxt();
        bus.ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_in = '0; bus.mask_wr = 1'b0; bus.mask_in = '0;
        bus.ack = 1'b0; bus.ack_idx = '0; bus.ovf_clr = 1'b0;
        repeat (3) nxt();
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        nxt();
        chk_all_zero("post_reset");

        // First-event latency: pending appears S edges after the sampling edge.
        bus.req_in = 8'h01;
        nxt(); nxt();
        chk("lat_early", 32'(bus.pend_out), 32'h00);
        nxt();
        chk("lat_pend", 32'(bus.pend_out), 32'h01);
        chk("lat_irq", 32'(bus.irq), 32'h1);
        bus.req_in = '0;
        do_ack(0);
        chk("ack0", 32'(bus.pend_out), 32'h00);

        for (int i = 1; i < N; i++) begin
            bus.req_in = N'(1) << i;
            repeat (3) nxt();
            chk("walk_set", 32'(bus.pend_out), 32'(N'(1) << i));
            bus.req_in = '0;
            do_ack(i);
            chk("walk_clr", 32'(bus.pend_out), 32'h00);
        end

        // Masked line still latches; unmasking exposes it.
        bus.req_in = 8'h90; bus.mask_wr = 1'b1; bus.mask_in = 8'h80;
        nxt();
        bus.mask_wr = 1'b0;
        chk("mask_q", 32'(bus.mask_q), 32'h80);
        repeat (2) nxt();
        chk("mask_pend", 32'(bus.pend_out), 32'h10);
        chk("mask_irq", 32'(bus.irq), 32'h1);
        bus.mask_wr = 1'b1; bus.mask_in = 8'h00;
        nxt();
        bus.mask_wr = 1'b0;
        chk("unmask_pend", 32'(bus.pend_out), 32'h90);
        bus.req_in = '0;
        do_ack(4);
        do_ack(7);
        chk("mask_drain", 32'(bus.pend_out), 32'h00);

        // Second edge on an unserviced line sets overflow.
        bus.req_in = 8'h08;
        repeat (3) nxt();
        bus.req_in = 8'h00;
        nxt();
        bus.req_in = 8'h08;
        repeat (3) nxt();
        chk("ovf_set", 32'(bus.overflow), 32'h08);
        chk("ovf_pend", 32'(bus.pend_out), 32'h08);
        bus.ovf_clr = 1'b1;
        nxt();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'h00);
        bus.req_in = '0;
        do_ack(3);
        nxt();

        // Ack coinciding with a new edge on the same line: no overflow, bit stays set.
        bus.req_in = 8'h20;
        repeat (3) nxt();
        bus.req_in = 8'h00;
        nxt(); nxt();
        bus.req_in = 8'h20;
        nxt(); nxt();
        do_ack(5);
        chk("same_pend", 32'(bus.pend_out), 32'h20);
        chk("same_ovf", 32'(bus.overflow), 32'h00);
        do_ack(5);
        chk("same_clr", 32'(bus.pend_out), 32'h00);
        bus.req_in = '0;
        nxt();

        // Asynchronous reset mid-cycle, with requests held across release.
        bus.req_in = 8'h24;
        repeat (3) nxt();
        chk("pre_rst", 32'(bus.pend_out), 32'h24);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (3) nxt();
        rst_n = 1'b1;
        nxt(); nxt();
        chk("rel_early", 32'(bus.pend_out), 32'h00);
        nxt();
        chk("rel_pend", 32'(bus.pend_out), 32'h24);

        for (int c = 0; c < 3000; c++) begin
            bus.req_in  = bus.req_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
            bus.ack     = ($urandom_range(0, 2) == 0);
            bus.ack_idx = IW'($urandom);
            bus.mask_wr = ($urandom_range(0, 15) == 0);
            bus.mask_in = N'($urandom);
            bus.ovf_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                repeat (3) nxt();
                rst_n = 1'b1;
            end
            nxt();
        end
        bus.ack = 1'b0; bus.mask_wr = 1'b0; bus.ovf_clr = 1'b0;
        repeat (4) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
